// File: rtl/reg_bank_sb.sv
// Parametrised register bank: muxed write port, two bypassed read ports, and a busy-bit
// scoreboard that flags reads of registers still waiting on a multi-cycle result.
module reg_bank_sb #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned NREGS   = 8,
    parameter int unsigned AW      = $clog2(NREGS),
    parameter bit          ZERO_R0 = 1'b0
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [WIDTH-1:0]       ALU,
    input  logic [WIDTH-1:0]       REG,
    input  logic [WIDTH-1:0]       IMM,
    input  logic [WIDTH-1:0]       MEM,
    input  logic [1:0]             MS,
    input  logic                   WE,
    input  logic [AW-1:0]          WA,
    input  logic                   ISSUE,
    input  logic [AW-1:0]          ISSUE_A,
    input  logic [AW-1:0]          RA0,
    input  logic [AW-1:0]          RA1,
    output logic [WIDTH-1:0]       RD0,
    output logic [WIDTH-1:0]       RD1,
    output logic                   STALL0,
    output logic                   STALL1,
    output logic [NREGS-1:0]       BUSY,
    output logic                   ISSUE_ERR,
    output logic [NREGS*WIDTH-1:0] RALL
);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] wd;
    logic             we_eff, issue_eff;

    always_comb begin
        unique case (MS)
            2'd0: wd = ALU;
            2'd1: wd = REG;
            2'd2: wd = IMM;
            2'd3: wd = MEM;
        endcase
    end

    // With ZERO_R0, anything aimed at address 0 is dropped before it reaches state or bypass.
    assign we_eff    = WE & ~(ZERO_R0 && (WA == '0));
    assign issue_eff = ISSUE & ~(ZERO_R0 && (ISSUE_A == '0));

    // Issue is applied after the write-clear so a same-edge issue leaves the register busy.
    always_comb begin
        busy_d = busy_q;
        if (we_eff) busy_d[WA] = 1'b0;
        if (issue_eff) busy_d[ISSUE_A] = 1'b1;
        err_d = err_q | (issue_eff & busy_q[ISSUE_A] & ~(we_eff && (WA == ISSUE_A)));
    end

    always_ff @(negedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (we_eff) regs_q[WA] <= wd;
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    always_comb begin
        RD0    = regs_q[RA0];
        STALL0 = busy_q[RA0];
        if (we_eff && (WA == RA0)) begin
            RD0    = wd;
            STALL0 = 1'b0;
        end
        if (ZERO_R0 && (RA0 == '0)) begin
            RD0    = '0;
            STALL0 = 1'b0;
        end
    end

    always_comb begin
        RD1    = regs_q[RA1];
        STALL1 = busy_q[RA1];
        if (we_eff && (WA == RA1)) begin
            RD1    = wd;
            STALL1 = 1'b0;
        end
        if (ZERO_R0 && (RA1 == '0)) begin
            RD1    = '0;
            STALL1 = 1'b0;
        end
    end

    assign BUSY      = busy_q;
    assign ISSUE_ERR = err_q;

    for (genvar g = 0; g < NREGS; g++) begin : g_rall
        assign RALL[g*WIDTH +: WIDTH] = (ZERO_R0 && (g == 0)) ? '0 : regs_q[g];
    end

endmodule

// File: tb/tb_reg_bank_sb.sv
// Directed bench for reg_bank_sb: default 8x8 instance plus a 16x16 ZERO_R0 instance.
module tb_reg_bank_sb;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    // Instance A: WIDTH=8, NREGS=8, ZERO_R0=0
    logic [7:0]  a_alu, a_reg, a_imm, a_mem;
    logic [1:0]  a_ms;
    logic        a_we, a_issue;
    logic [2:0]  a_wa, a_issue_a, a_ra0, a_ra1;
    logic [7:0]  a_rd0, a_rd1;
    logic        a_stall0, a_stall1, a_err;
    logic [7:0]  a_busy;
    logic [63:0] a_rall;

    // Instance B: WIDTH=16, NREGS=16, ZERO_R0=1
    logic [15:0]  b_alu, b_reg, b_imm, b_mem;
    logic [1:0]   b_ms;
    logic         b_we, b_issue;
    logic [3:0]   b_wa, b_issue_a, b_ra0, b_ra1;
    logic [15:0]  b_rd0, b_rd1;
    logic         b_stall0, b_stall1, b_err;
    logic [15:0]  b_busy;
    logic [255:0] b_rall;

    reg_bank_sb u_a (
        .CLK(clk), .RST_N(rst_n), .ALU(a_alu), .REG(a_reg), .IMM(a_imm), .MEM(a_mem),
        .MS(a_ms), .WE(a_we), .WA(a_wa), .ISSUE(a_issue), .ISSUE_A(a_issue_a),
        .RA0(a_ra0), .RA1(a_ra1), .RD0(a_rd0), .RD1(a_rd1), .STALL0(a_stall0),
        .STALL1(a_stall1), .BUSY(a_busy), .ISSUE_ERR(a_err), .RALL(a_rall)
    );

    reg_bank_sb #(.WIDTH(16), .NREGS(16), .ZERO_R0(1'b1)) u_b (
        .CLK(clk), .RST_N(rst_n), .ALU(b_alu), .REG(b_reg), .IMM(b_imm), .MEM(b_mem),
        .MS(b_ms), .WE(b_we), .WA(b_wa), .ISSUE(b_issue), .ISSUE_A(b_issue_a),
        .RA0(b_ra0), .RA1(b_ra1), .RD0(b_rd0), .RD1(b_rd1), .STALL0(b_stall0),
        .STALL1(b_stall1), .BUSY(b_busy), .ISSUE_ERR(b_err), .RALL(b_rall)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next falling (active) edge and settle.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n = 1'b0;
        a_alu = '0; a_reg = '0; a_imm = '0; a_mem = '0; a_ms = '0; a_we = 1'b0;
        a_wa = '0; a_issue = 1'b0; a_issue_a = '0; a_ra0 = '0; a_ra1 = '0;
        b_alu = '0; b_reg = '0; b_imm = '0; b_mem = '0; b_ms = '0; b_we = 1'b0;
        b_wa = '0; b_issue = 1'b0; b_issue_a = '0; b_ra0 = '0; b_ra1 = '0;

        tick();
        check_eq("rst_rall", a_rall, 64'h0);
        check_eq("rst_busy", a_busy, 8'h00);
        check_eq("rst_err", a_err, 1'b0);
        #2 rst_n = 1'b1;

        // Reset/basic write
        a_we = 1'b1; a_ms = 2'd2; a_imm = 8'h7B; a_wa = 3'd3; a_ra0 = 3'd3;
        #1 check_eq("basic_bypass_rd0", a_rd0, 8'h7B);
        tick();
        a_we = 1'b0;
        #1;
        check_eq("basic_rall", a_rall, 64'h0000_0000_7B00_0000);
        check_eq("basic_rd0", a_rd0, 8'h7B);

        // Source mux
        a_alu = 8'h11; a_reg = 8'h22; a_imm = 8'h33; a_mem = 8'h44;
        for (int i = 0; i < 4; i++) begin
            a_we = 1'b1; a_ms = 2'(i); a_wa = 3'(i);
            tick();
        end
        a_we = 1'b0; a_wa = 3'd0; a_ms = 2'd3;
        tick();
        check_eq("mux_rall", a_rall, 64'h0000_0000_4433_2211);

        // Bypass
        a_we = 1'b1; a_wa = 3'd5; a_ms = 2'd0; a_alu = 8'h10;
        tick();
        a_alu = 8'hAA; a_ra1 = 3'd5;
        #1 check_eq("bypass_rd1", a_rd1, 8'hAA);
        tick();
        a_we = 1'b0;
        #1;
        check_eq("bypass_rall", a_rall, 64'h0000_AA00_4433_2211);
        check_eq("bypass_rd1_stored", a_rd1, 8'hAA);

        // Scoreboard
        a_issue = 1'b1; a_issue_a = 3'd6;
        tick();
        a_issue = 1'b0; a_ra0 = 3'd6;
        #1;
        check_eq("sb_busy", a_busy, 8'h40);
        check_eq("sb_stall0", a_stall0, 1'b1);
        a_we = 1'b1; a_wa = 3'd6; a_ms = 2'd3; a_mem = 8'h5C;
        #1;
        check_eq("sb_stall0_resolved", a_stall0, 1'b0);
        check_eq("sb_rd0_bypass", a_rd0, 8'h5C);
        tick();
        a_we = 1'b0;
        #1;
        check_eq("sb_busy_clear", a_busy, 8'h00);
        check_eq("sb_err_clean", a_err, 1'b0);

        // Double issue on reg2 sets sticky error
        a_issue = 1'b1; a_issue_a = 3'd2;
        tick();
        check_eq("dbl_err_first", a_err, 1'b0);
        tick();
        a_issue = 1'b0;
        #1;
        check_eq("dbl_err", a_err, 1'b1);
        check_eq("dbl_busy", a_busy, 8'h04);
        a_we = 1'b1; a_wa = 3'd2; a_ms = 2'd2; a_imm = 8'h99;
        tick();
        a_we = 1'b0;
        #1;
        check_eq("dbl_busy_cleared", a_busy, 8'h00);
        check_eq("dbl_err_sticky", a_err, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("dbl_err_rst", a_err, 1'b0);
        check_eq("dbl_rall_rst", a_rall, 64'h0);
        rst_n = 1'b1;

        // Same-edge write+issue on reg4, plus independent write reg1 / issue reg7
        a_we = 1'b1; a_wa = 3'd4; a_ms = 2'd1; a_reg = 8'h22;
        a_issue = 1'b1; a_issue_a = 3'd4;
        tick();
        a_we = 1'b0; a_issue = 1'b0; a_ra1 = 3'd4;
        #1;
        check_eq("same_rall", a_rall, 64'h0000_0022_0000_0000);
        check_eq("same_busy", a_busy, 8'h10);
        check_eq("same_err", a_err, 1'b0);
        check_eq("same_stall1", a_stall1, 1'b1);
        check_eq("same_rd1", a_rd1, 8'h22);
        a_we = 1'b1; a_wa = 3'd1; a_ms = 2'd0; a_alu = 8'h3C;
        a_issue = 1'b1; a_issue_a = 3'd7;
        tick();
        a_we = 1'b0; a_issue = 1'b0;
        #1;
        check_eq("indep_rall", a_rall, 64'h0000_0022_0000_3C00);
        check_eq("indep_busy", a_busy, 8'h90);
        check_eq("indep_err", a_err, 1'b0);

        // Instance B: R0 hardwired to zero
        b_we = 1'b1; b_wa = 4'd0; b_ms = 2'd2; b_imm = 16'hFFFF; b_ra0 = 4'd0;
        #1 check_eq("z_rd0_bypass", b_rd0, 16'h0000);
        tick();
        b_we = 1'b0; b_issue = 1'b1; b_issue_a = 4'd0;
        tick();
        tick();
        b_issue = 1'b0;
        #1;
        check_eq("z_busy", b_busy, 16'h0000);
        check_eq("z_stall0", b_stall0, 1'b0);
        check_eq("z_rd0", b_rd0, 16'h0000);
        check_eq("z_err", b_err, 1'b0);
        check_eq("z_rall", b_rall, 256'h0);

        b_we = 1'b1; b_wa = 4'd15; b_ms = 2'd2; b_imm = 16'hBEEF; b_ra1 = 4'd15;
        #1 check_eq("z_r15_bypass", b_rd1, 16'hBEEF);
        tick();
        b_we = 1'b0;
        #1;
        check_eq("z_r15_rd1", b_rd1, 16'hBEEF);
        check_eq("z_r15_rall", b_rall[255:240], 16'hBEEF);

        // Async reset while reg9 load is pending
        b_issue = 1'b1; b_issue_a = 4'd9;
        tick();
        b_issue = 1'b0; b_ra0 = 4'd9;
        #1;
        check_eq("z_r9_busy", b_busy, 16'h0200);
        check_eq("z_r9_stall0", b_stall0, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("z_async_busy", b_busy, 16'h0000);
        check_eq("z_async_stall0", b_stall0, 1'b0);
        check_eq("z_async_rall", b_rall, 256'h0);
        rst_n = 1'b1;
        b_we = 1'b1; b_wa = 4'd9; b_ms = 2'd3; b_mem = 16'h1234;
        tick();
        b_we = 1'b0;
        #1;
        check_eq("z_r9_late_rall", b_rall[159:144], 16'h1234);
        check_eq("z_r9_late_busy", b_busy, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_bank_sb.md
Name: reg_bank_sb

Overview:
- Parametrised successor to the 8x8 register bank.
- NREGS registers of WIDTH bits, one write port fed by a 4-way write-source mux (ALU/REG/IMM/MEM), two read ports with write-through bypass.
- Busy-bit scoreboard marks registers awaiting a multi-cycle result (MEM loads) and raises per-port stall flags.
- Sits between decoder/sequencer and ALU; all register contents also exported flat for debug/ALU operand muxing.

Parameters:
- WIDTH, 8, register width in bits.
- NREGS, 8, register count; power of two, 2..32.
- AW, $clog2(NREGS), address width (derived; not overridden).
- ZERO_R0, 0, 1 = R0 reads as 0 and ignores writes and issues.

Ports:
- CLK  in  1  clock; all state updates on the FALLING edge (codebase convention).
- RST_N  in  1  asynchronous active-low reset.
- ALU  in  WIDTH  write source 0.
- REG  in  WIDTH  write source 1.
- IMM  in  WIDTH  write source 2.
- MEM  in  WIDTH  write source 3.
- MS  in  2  write-source select: {MS1,MS0}; 0=ALU 1=REG 2=IMM 3=MEM.
- WE  in  1  write enable (replaces old global E).
- WA  in  AW  write address.
- ISSUE  in  1  mark register ISSUE_A busy (pending result).
- ISSUE_A  in  AW  address to mark busy.
- RA0  in  AW  read address, port 0.
- RA1  in  AW  read address, port 1.
- RD0  out  WIDTH  read data, port 0 (combinational).
- RD1  out  WIDTH  read data, port 1 (combinational).
- STALL0  out  1  RA0 targets a busy register not resolved this cycle.
- STALL1  out  1  same for RA1.
- BUSY  out  NREGS  scoreboard bits, bit i = register i.
- ISSUE_ERR  out  1  sticky: ISSUE hit an already-busy register.
- RALL  out  NREGS*WIDTH  flat contents; register i at [i*WIDTH +: WIDTH].

Behaviour:
- Reset (RST_N=0, async, any time): all registers 0, BUSY=0, ISSUE_ERR=0. Falling edges ignored while low. Reset mid-pending-load discards the busy state; a later MEM write lands normally.
- Write data WD = mux(MS). On falling CLK edge with WE=1: reg[WA] <= WD, and BUSY[WA] <= 0.
- WE=0: no register changes regardless of MS/WA.
- ISSUE=1 at falling edge: BUSY[ISSUE_A] <= 1. If BUSY[ISSUE_A] already 1 (before edge, not cleared by the same-edge write), ISSUE_ERR <= 1 (sticky until reset); BUSY stays 1.
- Same-edge WE and ISSUE to same address: write data stored, BUSY ends 1 (issue wins: new pending producer). No ISSUE_ERR.
- Same-edge WE and ISSUE to different addresses: both take effect independently.
- Read (combinational, zero latency): RDn = WD if WE=1 and WA==RAn (bypass), else reg[RAn].
- STALLn = BUSY[RAn] & ~(WE & WA==RAn). A bypassed write resolves the stall in the same cycle.
- ZERO_R0=1: RDn=0 and STALLn=0 when RAn==0. Writes, ISSUE, and bypass to address 0 are dropped. BUSY[0] is always 0. RALL slice 0 is 0.
- RALL reflects stored state only (no bypass).
- Addresses are always in range (NREGS power of two); no wrap logic needed.
- Width rules: no arithmetic; inputs are stored verbatim.

Test Plan:
- Reset/basic write: RST_N low then high; WE=1, MS=2, IMM=8'h7B, WA=3, falling edge -> RALL slice 3=8'h7B, all others 0; RA0=3 -> RD0=8'h7B.
- Source mux: ALU=8'h11, REG=8'h22, IMM=8'h33, MEM=8'h44. Write MS=0..3 to regs 0..3 on four edges -> regs hold 11,22,33,44. A WE=0 edge with WA=0 leaves them unchanged.
- Bypass: reg5=8'h10. Same cycle WE=1, WA=5, MS=0, ALU=8'hAA, RA1=5 -> RD1=8'hAA before the edge; after the edge reg5=8'hAA.
- Scoreboard: ISSUE_A=6, ISSUE=1, edge -> BUSY=8'h40. RA0=6 -> STALL0=1. Apply WE=1, WA=6, MS=3, MEM=8'h5C -> STALL0=0 combinationally, RD0=8'h5C. After the edge BUSY=0.
- Conflicts: issue reg2 twice on consecutive edges -> ISSUE_ERR=1, held through later writes until RST_N pulse. Same-edge WE+ISSUE on reg4 -> reg4 written, BUSY[4]=1, ISSUE_ERR unchanged.
- ZERO_R0=1, WIDTH=16, NREGS=16: write 16'hFFFF to reg0 and ISSUE reg0 -> RD0(RA0=0)=0, BUSY[0]=0, STALL0=0. Reg15 write/read 16'hBEEF works. Assert RST_N mid-pending on reg9 -> BUSY cleared asynchronously, without waiting for an edge.
